div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, giving the operand/result width in bits (even, >= 4).
REQ-002 The block SHALL have the parameter RADIX_BITS, default 1, giving the quotient bits retired per iteration cycle (1 or 2; WIDTH % RADIX_BITS == 0).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_ni  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  request; accepted when start_i & ready_o & !kill_i.
REQ-007 op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
REQ-008 dividend_i  input  WIDTH  numerator; sampled at accept.
REQ-009 divisor_i  input  WIDTH  denominator; sampled at accept.
REQ-010 kill_i  input  1  synchronous abort of any in-flight operation.
REQ-011 ready_o  output  1  equals !busy_o.
REQ-012 busy_o  output  1  operation in flight.
REQ-013 done_o  output  1  one-cycle pulse; results valid from this cycle.
REQ-014 dbz_o  output  1  last completed op had a zero divisor.
REQ-015 ovf_o  output  1  last completed op was signed MIN / -1.
REQ-016 quotient_o  output  WIDTH  last quotient.
REQ-017 remainder_o  output  WIDTH  last remainder.
REQ-018 result_o  output  WIDTH  quotient_o for DIV/DIVU, remainder_o for REM/REMU.

Function
REQ-019 The FSM SHALL have states IDLE, CALC and FIXUP; busy_o SHALL be high exactly in CALC and FIXUP.
REQ-020 Signed ops (DIV, REM) SHALL divide magnitudes as unsigned WIDTH-bit values; |MIN| is taken as the unsigned value 2^(WIDTH-1).
REQ-021 Signed quotient sign SHALL be sign(dividend) xor sign(divisor); signed remainder sign SHALL equal sign(dividend).
REQ-022 Divisor zero: quotient = all ones, remainder = dividend, dbz_o = 1, ovf_o = 0, for all four ops.
REQ-023 Signed overflow (DIV/REM, dividend = MIN, divisor = all ones): quotient = MIN, remainder = 0, ovf_o = 1, dbz_o = 0.
REQ-024 A special case (REQ-022/023) SHALL bypass CALC and FIXUP; the FSM stays in IDLE and done_o pulses in the cycle after the accept edge.
REQ-025 On a normal accept, the FSM SHALL enter CALC for N = WIDTH/RADIX_BITS cycles, shifting-subtracting RADIX_BITS quotient bits per cycle, then enter FIXUP for 1 cycle to apply signs, then return to IDLE.
REQ-026 For a normal op, done_o SHALL pulse N+2 cycles after the accept edge, in the first IDLE cycle.
REQ-027 The iteration counter SHALL be wide enough to hold N without wrap.
REQ-028 quotient_o, remainder_o, result_o, dbz_o and ovf_o SHALL update only on a done_o cycle and hold until the next done_o.
REQ-029 start_i while busy_o is high SHALL be ignored with no effect on state or outputs.
REQ-030 kill_i SHALL return the FSM to IDLE at the next edge; no done_o SHALL pulse for the aborted op, and the result outputs SHALL keep their prior values.
REQ-031 kill_i SHALL have priority over start_i in the same cycle, so that no accept occurs.
REQ-032 A new start_i SHALL be accepted in the done_o cycle (back-to-back), with no idle bubble required.
REQ-033 Operands SHALL be registered at accept; input changes after accept SHALL not affect the result.

Reset
REQ-034 While rst_ni is asserted, the FSM SHALL be IDLE and busy_o, done_o, dbz_o, ovf_o, quotient_o, remainder_o and result_o SHALL be 0, with ready_o = 1, asynchronously.
REQ-035 Reset asserted mid-operation SHALL discard the operation, and no done_o SHALL follow deassertion.

Verification
REQ-036 WIDTH=32, RADIX_BITS=1: DIVU 100/7 -> done_o pulses 34 cycles after accept, quotient_o=14, remainder_o=2, result_o=14; REMU with the same operands gives result_o=2.
REQ-037 DIV -7/2 -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD and 1.
REQ-038 DIVU 0x55/0 -> 1 cycle later: done_o=1, dbz_o=1, quotient_o=0xFFFFFFFF, remainder_o=0x55.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> 1 cycle later: ovf_o=1, quotient_o=0x80000000, remainder_o=0; DIVU with the same operands -> normal path, quotient_o=0, remainder_o=0x80000000.
REQ-040 Start DIVU 1000/3, assert kill_i on cycle 10 -> no done_o, ready_o=1 next cycle, prior results unchanged; an immediate new DIVU 9/3 -> quotient_o=3.
REQ-041 RADIX_BITS=2: DIVU 0xFFFFFFFF/0x10 -> done_o after 18 cycles, quotient_o=0x0FFFFFFF, remainder_o=0xF; rst_ni asserted mid-CALC -> all outputs 0 and no done_o.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for signed and unsigned DIV/REM, retiring RADIX_BITS quotient bits per cycle.
// A zero divisor or signed MIN/-1 skips the iteration and completes one cycle after accept.
//   state | meaning
//   IDLE  | ready; accepts ops and finishes special cases directly
//   CALC  | shift-subtract iterations on operand magnitudes
//   FIXUP | sign correction and publishing of results
module div_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             kill_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int               N        = WIDTH / RADIX_BITS;
  localparam int               CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] quo_q, rem_q, div_q, quo_d, rem_d;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [WIDTH:0]   trial, diff;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q, neg_r_q, is_rem_q, sel_rem_q;
  logic             accept, is_signed, dvd_neg, dvs_neg, zero_div, ovf_case, special;

  assign busy_o    = (state_q != IDLE);
  assign ready_o   = ~busy_o;
  assign accept    = start_i & ready_o & ~kill_i;
  assign is_signed = ~op_i[0];
  assign dvd_neg   = is_signed & dividend_i[WIDTH-1];
  assign dvs_neg   = is_signed & divisor_i[WIDTH-1];
  // Negating MIN yields MIN, which is exactly |MIN| read as unsigned.
  assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag   = dvs_neg ? -divisor_i : divisor_i;
  assign zero_div  = (divisor_i == '0);
  assign ovf_case  = is_signed & (dividend_i == MIN_VAL) & (divisor_i == '1);
  assign special   = zero_div | ovf_case;
  assign quo_fix   = neg_q_q ? -quo_q : quo_q;
  assign rem_fix   = neg_r_q ? -rem_q : rem_q;
  assign result_o  = sel_rem_q ? remainder_o : quotient_o;

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !special) state_d = CALC;
      CALC: begin
        if (kill_i)                state_d = IDLE;
        else if (cnt_q == CNT_ONE) state_d = FIXUP;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Partial remainder stays below the divisor, so the diff sign bit selects restore vs. subtract.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    trial = '0;
    diff  = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      trial = {rem_d, quo_d[WIDTH-1]};
      diff  = trial - {1'b0, div_q};
      quo_d = {quo_d[WIDTH-2:0], ~diff[WIDTH]};
      rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      is_rem_q    <= 1'b0;
      sel_rem_q   <= 1'b0;
      done_o      <= 1'b0;
      dbz_o       <= 1'b0;
      ovf_o       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        if (special) begin
          done_o      <= 1'b1;
          dbz_o       <= zero_div;
          ovf_o       <= ovf_case;
          quotient_o  <= zero_div ? '1 : MIN_VAL;
          remainder_o <= zero_div ? dividend_i : '0;
          sel_rem_q   <= op_i[1];
        end else begin
          quo_q    <= dvd_mag;
          rem_q    <= '0;
          div_q    <= dvs_mag;
          cnt_q    <= CNT_LOAD;
          neg_q_q  <= dvd_neg ^ dvs_neg;
          neg_r_q  <= dvd_neg;
          is_rem_q <= op_i[1];
        end
      end else if (state_q == CALC && !kill_i) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q - CNT_ONE;
      end else if (state_q == FIXUP && !kill_i) begin
        done_o      <= 1'b1;
        dbz_o       <= 1'b0;
        ovf_o       <= 1'b0;
        quotient_o  <= quo_fix;
        remainder_o <= rem_fix;
        sel_rem_q   <= is_rem_q;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: radix-1 and radix-2 instances share stimulus and are
// checked against fixed vectors, an arithmetic reference model and kill/reset/back-to-back sequences.
module tb_div_unit;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;

  logic [1:0]  ready, busy, done, dbz, ovf;
  logic [31:0] quo [2];
  logic [31:0] rem [2];
  logic [31:0] res [2];

  int n_pass = 0;
  int n_total = 0;
  int lat_exp [2] = '{34, 18};
  logic [31:0] prev_q, prev_r, prev_res;
  logic        prev_dbz, prev_ovf;

  div_unit #(.WIDTH(32), .RADIX_BITS(1)) u_r1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .kill_i(kill_i),
    .ready_o(ready[0]), .busy_o(busy[0]), .done_o(done[0]), .dbz_o(dbz[0]), .ovf_o(ovf[0]),
    .quotient_o(quo[0]), .remainder_o(rem[0]), .result_o(res[0]));

  div_unit #(.WIDTH(32), .RADIX_BITS(2)) u_r2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .kill_i(kill_i),
    .ready_o(ready[1]), .busy_o(busy[1]), .done_o(done[1]), .dbz_o(dbz[1]), .ovf_o(ovf[1]),
    .quotient_o(quo[1]), .remainder_o(rem[1]), .result_o(res[1]));

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   m;
    longint sa, sb;
    m.dbz = 1'b0;
    m.ovf = 1'b0;
    if (b == 32'd0) begin
      m.q = 32'hFFFF_FFFF; m.r = a; m.dbz = 1'b1;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.q = 32'h8000_0000; m.r = 32'd0; m.ovf = 1'b1;
    end else if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m.q = 32'(sa / sb);
      m.r = 32'(sa % sb);
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  // Samples starting at the current time as cycle 1 after the accept edge.
  task automatic wait_done(input bit hammer, output int lat [2], output int np [2]);
    lat = '{0, 0};
    np  = '{0, 0};
    for (int c = 1; c <= 40; c++) begin
      if (hammer && c == 6) start_i = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          np[d]++;
          if (lat[d] == 0) lat[d] = c;
        end
      end
      if (c < 40) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic check_res(input string tag, input logic [1:0] op, input logic [31:0] eq,
                           input logic [31:0] er, input logic ed, input logic eo,
                           input int lat [2], input int np [2]);
    logic [31:0] eres;
    eres = op[1] ? er : eq;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s r%0d latency", tag, d + 1), 32'(lat[d]), (ed | eo) ? 32'd1 : 32'(lat_exp[d]));
      chk($sformatf("%s r%0d done_pulses", tag, d + 1), 32'(np[d]), 32'd1);
      chk($sformatf("%s r%0d quotient", tag, d + 1), quo[d], eq);
      chk($sformatf("%s r%0d remainder", tag, d + 1), rem[d], er);
      chk($sformatf("%s r%0d result", tag, d + 1), res[d], eres);
      chk($sformatf("%s r%0d dbz", tag, d + 1), 32'(dbz[d]), 32'(ed));
      chk($sformatf("%s r%0d ovf", tag, d + 1), 32'(ovf[d]), 32'(eo));
    end
    prev_q = eq; prev_r = er; prev_res = eres; prev_dbz = ed; prev_ovf = eo;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit hammer, input logic [31:0] eq,
                       input logic [31:0] er, input logic ed, input logic eo);
    int lat [2];
    int np [2];
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
    @(posedge clk_i);
    #1;
    if (!hammer) start_i = 1'b0;
    op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
    wait_done(hammer, lat, np);
    start_i = 1'b0;
    check_res(tag, op, eq, er, ed, eo, lat, np);
  endtask

  vec_t vecs [16];

  initial begin
    int   lat [2];
    int   np [2];
    int   cnt;
    res_t m;
    logic [31:0] a, b;
    logic [1:0]  op;
    bit   hammer;

    vecs = '{
      '{2'b01, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0},
      '{2'b11, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0},
      '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0},
      '{2'b01, 32'h55,        32'd0,         32'hFFFF_FFFF, 32'h55,        1'b1, 1'b0},
      '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1},
      '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0},
      '{2'b01, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         1'b0, 1'b0},
      '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{2'b10, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0},
      '{2'b11, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0},
      '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1},
      '{2'b00, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 1'b0},
      '{2'b01, 32'd3,         32'd5,         32'd0,         32'd3,         1'b0, 1'b0},
      '{2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0},
      '{2'b01, 32'h1234_5678, 32'h1234_5678, 32'd1,         32'd0,         1'b0, 1'b0}
    };

    // Reset state, checked while reset is held.
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset r%0d ready", d + 1), 32'(ready[d]), 32'd1);
      chk($sformatf("reset r%0d busy", d + 1), 32'(busy[d]), 32'd0);
      chk($sformatf("reset r%0d done", d + 1), 32'(done[d]), 32'd0);
      chk($sformatf("reset r%0d result", d + 1), res[d], 32'd0);
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 16; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            !(vecs[i].dbz | vecs[i].ovf) && (i % 3 == 0),
            vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(0, 15);
        1: b = b >> $urandom_range(1, 31);
        2: a = a >> $urandom_range(1, 31);
        default: ;
      endcase
      if ($urandom_range(0, 19) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      m = model(op, a, b);
      hammer = !(m.dbz | m.ovf) && ($urandom_range(0, 1) == 1);
      do_op($sformatf("rnd%0d", i), op, a, b, hammer, m.q, m.r, m.dbz, m.ovf);
    end

    // Kill at cycle 10 of DIVU 1000/3.
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cnt = 0;
    for (int c = 1; c < 10; c++) begin
      cnt += int'(done[0]) + int'(done[1]);
      @(posedge clk_i);
      #1;
    end
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("kill r%0d ready_next", d + 1), 32'(ready[d]), 32'd1);
    for (int c = 0; c < 40; c++) begin
      cnt += int'(done[0]) + int'(done[1]);
      @(posedge clk_i);
      #1;
    end
    chk("kill done_pulses", 32'(cnt), 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("kill r%0d quotient_kept", d + 1), quo[d], prev_q);
      chk($sformatf("kill r%0d remainder_kept", d + 1), rem[d], prev_r);
      chk($sformatf("kill r%0d result_kept", d + 1), res[d], prev_res);
      chk($sformatf("kill r%0d dbz_kept", d + 1), 32'(dbz[d]), 32'(prev_dbz));
      chk($sformatf("kill r%0d ovf_kept", d + 1), 32'(ovf[d]), 32'(prev_ovf));
    end
    do_op("after_kill", 2'b01, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

    // Kill and start together: no accept, not even of a special case.
    start_i = 1'b1; kill_i = 1'b1; op_i = 2'b01; dividend_i = 32'd77; divisor_i = 32'd0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; kill_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cnt += int'(done[0]) + int'(done[1]) + int'(busy[0]) + int'(busy[1]);
      @(posedge clk_i);
      #1;
    end
    chk("kill_prio no_accept", 32'(cnt), 32'd0);
    chk("kill_prio quotient_kept", quo[0], 32'd3);

    // Back-to-back: special op, then a normal op accepted in its done cycle.
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'h55; divisor_i = 32'd0;
    @(posedge clk_i);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("b2b r%0d first_done", d + 1), 32'(done[d]), 32'd1);
      chk($sformatf("b2b r%0d first_quotient", d + 1), quo[d], 32'hFFFF_FFFF);
    end
    op_i = 2'b11; dividend_i = 32'd100; divisor_i = 32'd7;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
    for (int d = 0; d < 2; d++)
      chk($sformatf("b2b r%0d second_busy", d + 1), 32'(busy[d]), 32'd1);
    wait_done(1'b0, lat, np);
    check_res("b2b second", 2'b11, 32'd14, 32'd2, 1'b0, 1'b0, lat, np);

    // Reset mid-CALC discards the op.
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'h10;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst r%0d ready", d + 1), 32'(ready[d]), 32'd1);
      chk($sformatf("midrst r%0d busy", d + 1), 32'(busy[d]), 32'd0);
      chk($sformatf("midrst r%0d quotient", d + 1), quo[d], 32'd0);
      chk($sformatf("midrst r%0d remainder", d + 1), rem[d], 32'd0);
      chk($sformatf("midrst r%0d result", d + 1), res[d], 32'd0);
      chk($sformatf("midrst r%0d dbz", d + 1), 32'(dbz[d]), 32'd0);
      chk($sformatf("midrst r%0d ovf", d + 1), 32'(ovf[d]), 32'd0);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cnt += int'(done[0]) + int'(done[1]) + int'(busy[0]) + int'(busy[1]);
      @(posedge clk_i);
      #1;
    end
    chk("midrst no_done", 32'(cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
